// File: rtl/lsu_split_16b.sv
// lsu_split_16b: splits odd-address 16-bit core accesses into two byte
// transfers for a 16-bit little-endian LSU and merges the byte lanes back
// into one aligned, extended response per core access.
// Optional build macro: LSU_SPLIT_SEXT_EN adds core_sext (byte-read sign
// extension); without it every byte read is zero-extended.
module lsu_split_16b #(
    parameter bit WRITE_RSP = 1'b1
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        core_valid,
    output logic        core_ready,
    input  logic [15:0] core_addr,
    input  logic [15:0] core_data,
    input  logic        core_width,
    input  logic        core_cmd,
    input  logic        core_t_id,
`ifdef LSU_SPLIT_SEXT_EN
    input  logic        core_sext,
`endif
    output logic [15:0] rq_addr,
    output logic        rq_wr_addr,
    output logic [15:0] rq_data,
    output logic        rq_width,
    output logic        rq_cmd,
    output logic        rq_t_id,
    output logic        rq_start,
    input  logic        rq_ack,
    input  logic        mem_rdy,
    input  logic [15:0] mem_rd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_t_id
);

    typedef enum logic [1:0] {IDLE, REQ1, REQ2, WAIT_LAST} state_e;

    state_e      state_q;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic        width_q;
    logic        cmd_q;
    logic        t_id_q;
    logic        split_q;
    logic        sext_q;
    logic [7:0]  lo_q;

    logic        rq_start_q;
    logic [15:0] rq_addr_q;
    logic [15:0] rq_data_q;
    logic        rq_width_q;

    logic        rsp_valid_q;
    logic [15:0] rsp_data_q;
    logic        rsp_t_id_q;

    logic        sext_in;
    logic        accept_split;
    logic [7:0]  sel_byte;
    logic        ext_bit;
    logic [15:0] rsp_data_d;

`ifdef LSU_SPLIT_SEXT_EN
    assign sext_in = core_sext;
`else
    assign sext_in = 1'b0;
`endif

    assign core_ready = (state_q == IDLE);
    assign rq_start   = rq_start_q;
    assign rq_addr    = rq_addr_q;
    assign rq_data    = rq_data_q;
    assign rq_width   = rq_width_q;
    assign rq_cmd     = cmd_q;
    assign rq_t_id    = t_id_q;
    assign rq_wr_addr = 1'b1;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_t_id   = rsp_t_id_q;

    // Split decision and merged/extended read data for the final completion.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        rsp_data_d   = 16'h0000;
        accept_split = core_addr[0] & ~core_width;
        sel_byte     = addr_q[0] ? mem_rd_data[15:8] : mem_rd_data[7:0];
        ext_bit      = sext_q & sel_byte[7];
        if (!cmd_q) begin
            if (split_q) begin
                rsp_data_d = {mem_rd_data[7:0], lo_q};
            end else if (width_q) begin
                rsp_data_d = {{8{ext_bit}}, sel_byte};
            end else begin
                rsp_data_d = mem_rd_data;
            end
        end
    end

    // Request sequencing FSM with registered LSU request and core response.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            // NOTE: every register, including the latched request, is reset so a split aborted midway leaves nothing behind.
            state_q     <= IDLE;
            addr_q      <= 16'h0000;
            data_q      <= 16'h0000;
            width_q     <= 1'b0;
            cmd_q       <= 1'b0;
            t_id_q      <= 1'b0;
            split_q     <= 1'b0;
            sext_q      <= 1'b0;
            lo_q        <= 8'h00;
            rq_start_q  <= 1'b0;
            rq_addr_q   <= 16'h0000;
            rq_data_q   <= 16'h0000;
            rq_width_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_t_id_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (core_valid) begin
                        addr_q     <= core_addr;
                        data_q     <= core_data;
                        width_q    <= core_width;
                        cmd_q      <= core_cmd;
                        t_id_q     <= core_t_id;
                        split_q    <= accept_split;
                        sext_q     <= sext_in;
                        rq_start_q <= 1'b1;
                        rq_addr_q  <= core_addr;
                        rq_width_q <= core_width | accept_split;
                        // Any odd-address first transfer is a byte on lane 1.
                        rq_data_q  <= core_addr[0] ? {core_data[7:0], core_data[7:0]} : core_data;
                        state_q    <= REQ1;
                    end
                end
                REQ1: begin
                    if (rq_ack) begin
                        if (split_q) begin
                            rq_addr_q <= addr_q + 16'd1;
                            rq_data_q <= {data_q[15:8], data_q[15:8]};
                            state_q   <= REQ2;
                        end else begin
                            rq_start_q <= 1'b0;
                            state_q    <= WAIT_LAST;
                        end
                    end
                end
                REQ2: begin
                    // Part-2 ack coincides with part-1 completion; odd byte sits on lane 1.
                    if (rq_ack) begin
                        lo_q       <= mem_rd_data[15:8];
                        rq_start_q <= 1'b0;
                        state_q    <= WAIT_LAST;
                    end
                end
                WAIT_LAST: begin
                    if (mem_rdy) begin
                        state_q <= IDLE;
                        if (!cmd_q || WRITE_RSP) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rsp_data_d;
                            rsp_t_id_q  <= t_id_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Part-1 completion without the part-2 acknowledge breaks the LSU contract.
    a_rdy_with_ack: assert property (@(posedge clk) disable iff (!a_rst)
        (state_q == REQ2 && mem_rdy) |-> rq_ack);

endmodule

// File: tb/tb_lsu_split_16b.sv
// Self-checking bench for lsu_split_16b: directed test-plan cases followed by
// randomized accesses, checked against a byte-level reference model. A second
// instance built with WRITE_RSP = 0 shares the stimulus.
module tb_lsu_split_16b;

`ifdef LSU_SPLIT_SEXT_EN
    localparam bit SEXT_EN = 1'b1;
`else
    localparam bit SEXT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        a_rst;
    logic        core_valid;
    logic [15:0] core_addr;
    logic [15:0] core_data;
    logic        core_width;
    logic        core_cmd;
    logic        core_t_id;
`ifdef LSU_SPLIT_SEXT_EN
    logic        core_sext;
`endif
    logic        rq_ack;
    logic        mem_rdy;
    logic [15:0] mem_rd_data;

    logic        core_ready, rq_wr_addr, rq_width, rq_cmd, rq_t_id, rq_start;
    logic [15:0] rq_addr, rq_data;
    logic        rsp_valid, rsp_t_id;
    logic [15:0] rsp_data;

    logic        nw_core_ready, nw_rq_wr_addr, nw_rq_width, nw_rq_cmd, nw_rq_t_id, nw_rq_start;
    logic [15:0] nw_rq_addr, nw_rq_data;
    logic        nw_rsp_valid, nw_rsp_t_id;
    logic [15:0] nw_rsp_data;

    int n_cmp  = 0;
    int n_fail = 0;

    bit          pend = 1'b0;
    logic [15:0] exp_data;
    logic        exp_tid;
    logic        exp_nw_valid;

    always #5 clk = ~clk;

    lsu_split_16b #(.WRITE_RSP(1'b1)) u_dut (
        .clk(clk), .a_rst(a_rst),
        .core_valid(core_valid), .core_ready(core_ready),
        .core_addr(core_addr), .core_data(core_data), .core_width(core_width),
        .core_cmd(core_cmd), .core_t_id(core_t_id),
`ifdef LSU_SPLIT_SEXT_EN
        .core_sext(core_sext),
`endif
        .rq_addr(rq_addr), .rq_wr_addr(rq_wr_addr), .rq_data(rq_data),
        .rq_width(rq_width), .rq_cmd(rq_cmd), .rq_t_id(rq_t_id),
        .rq_start(rq_start), .rq_ack(rq_ack),
        .mem_rdy(mem_rdy), .mem_rd_data(mem_rd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_t_id(rsp_t_id)
    );

    lsu_split_16b #(.WRITE_RSP(1'b0)) u_dut_nw (
        .clk(clk), .a_rst(a_rst),
        .core_valid(core_valid), .core_ready(nw_core_ready),
        .core_addr(core_addr), .core_data(core_data), .core_width(core_width),
        .core_cmd(core_cmd), .core_t_id(core_t_id),
`ifdef LSU_SPLIT_SEXT_EN
        .core_sext(core_sext),
`endif
        .rq_addr(nw_rq_addr), .rq_wr_addr(nw_rq_wr_addr), .rq_data(nw_rq_data),
        .rq_width(nw_rq_width), .rq_cmd(nw_rq_cmd), .rq_t_id(nw_rq_t_id),
        .rq_start(nw_rq_start), .rq_ack(rq_ack),
        .mem_rdy(mem_rdy), .mem_rd_data(mem_rd_data),
        .rsp_valid(nw_rsp_valid), .rsp_data(nw_rsp_data), .rsp_t_id(nw_rsp_t_id)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called once per cycle at the negedge: verifies the one-cycle response pulse.
    task automatic check_rsp_cycle();
        if (pend) begin
            check("rsp_valid", {15'd0, rsp_valid}, 16'd1);
            check("rsp_data", rsp_data, exp_data);
            check("rsp_t_id", {15'd0, rsp_t_id}, {15'd0, exp_tid});
            check("nw_rsp_valid", {15'd0, nw_rsp_valid}, {15'd0, exp_nw_valid});
            if (exp_nw_valid) begin
                check("nw_rsp_data", nw_rsp_data, exp_data);
                check("nw_rsp_t_id", {15'd0, nw_rsp_t_id}, {15'd0, exp_tid});
            end
            pend = 1'b0;
        end else begin
            check("rsp_quiet", {15'd0, rsp_valid}, 16'd0);
            check("nw_rsp_quiet", {15'd0, nw_rsp_valid}, 16'd0);
        end
    endtask

    task automatic idle_cycle();
        check_rsp_cycle();
        @(negedge clk);
    endtask

    // One complete core access. Entered and left at a negedge; on return the
    // current cycle is the one in which the response is expected.
    task automatic do_access(input logic cmd, input logic width, input logic [15:0] addr,
                             input logic [15:0] data, input logic tid, input logic sx,
                             input int d1, input int d2, input logic [7:0] b_lo,
                             input logic [7:0] b_hi, input logic [7:0] junk);
        logic        split;
        logic [15:0] exp_rq;
        logic [15:0] rd1;
        logic [15:0] rd_last;
        logic [15:0] expd;
        split = addr[0] & ~width;
        // Reference model: the access touches byte b_lo at addr and b_hi at addr+1;
        // each transfer returns its byte on lane (transfer address bit 0).
        rd1 = {b_lo, junk};
        if (!width && !addr[0])  rd_last = {b_hi, b_lo};
        else if (split)          rd_last = {junk, b_hi};
        else if (addr[0])        rd_last = {b_lo, junk};
        else                     rd_last = {junk, b_lo};
        if (cmd)        expd = 16'h0000;
        else if (width) expd = {{8{SEXT_EN && sx && b_lo[7]}}, b_lo};
        else            expd = {b_hi, b_lo};
        exp_rq = (split || (width && addr[0])) ? {data[7:0], data[7:0]} : data;

        // cycle 0: accept
        check_rsp_cycle();
        check("core_ready", {15'd0, core_ready}, 16'd1);
        core_valid = 1'b1; core_addr = addr; core_data = data;
        core_width = width; core_cmd = cmd; core_t_id = tid;
`ifdef LSU_SPLIT_SEXT_EN
        core_sext = sx;
`endif
        @(negedge clk);
        // cycle 1: first request
        check_rsp_cycle();
        core_valid = 1'b0;
        check("busy_ready", {15'd0, core_ready}, 16'd0);
        check("rq1_start", {15'd0, rq_start}, 16'd1);
        check("rq1_addr", rq_addr, addr);
        check("rq1_width", {15'd0, rq_width}, {15'd0, (split | width)});
        check("rq1_data", rq_data, exp_rq);
        check("rq1_cmd", {15'd0, rq_cmd}, {15'd0, cmd});
        check("rq1_tid", {15'd0, rq_t_id}, {15'd0, tid});
        check("rq_wr_addr", {15'd0, rq_wr_addr}, 16'd1);
        rq_ack = 1'b1;
        @(negedge clk);
        rq_ack = 1'b0;
        if (split) begin
            for (int i = 0; i <= d1; i++) begin
                check("rq2_start", {15'd0, rq_start}, 16'd1);
                check("rq2_addr", rq_addr, addr + 16'd1);
                check("rq2_width", {15'd0, rq_width}, 16'd1);
                check("rq2_data", rq_data, {data[15:8], data[15:8]});
                check("rq2_tid", {15'd0, rq_t_id}, {15'd0, tid});
                if (i == d1) begin
                    rq_ack = 1'b1; mem_rdy = 1'b1; mem_rd_data = rd1;
                end
                @(negedge clk);
            end
            rq_ack = 1'b0; mem_rdy = 1'b0; mem_rd_data = 16'($urandom);
        end
        for (int i = 0; i <= d2; i++) begin
            check("wait_start", {15'd0, rq_start}, 16'd0);
            check("wait_rsp", {15'd0, rsp_valid}, 16'd0);
            if (i == d2) begin
                mem_rdy = 1'b1; mem_rd_data = rd_last;
            end
            @(negedge clk);
        end
        mem_rdy = 1'b0; mem_rd_data = 16'($urandom);
        pend = 1'b1; exp_data = expd; exp_tid = tid; exp_nw_valid = ~cmd;
    endtask

    initial begin
        a_rst = 1'b0; core_valid = 1'b0; core_addr = '0; core_data = '0;
        core_width = 1'b0; core_cmd = 1'b0; core_t_id = 1'b0;
`ifdef LSU_SPLIT_SEXT_EN
        core_sext = 1'b0;
`endif
        rq_ack = 1'b0; mem_rdy = 1'b0; mem_rd_data = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {15'd0, core_ready}, 16'd1);
        check("rst_start", {15'd0, rq_start}, 16'd0);
        check("rst_valid", {15'd0, rsp_valid}, 16'd0);
        check("rst_data", rsp_data, 16'h0000);
        check("rst_tid", {15'd0, rsp_t_id}, 16'd0);
        a_rst = 1'b1;
        @(negedge clk);

        // Aligned word read, completion at cycle 3.
        do_access(1'b0, 1'b0, 16'h1000, 16'h0000, 1'b1, 1'b0, 0, 1, 8'hEF, 8'hBE, 8'h00);
        // Split word write at 2001.
        do_access(1'b1, 1'b0, 16'h2001, 16'hA55A, 1'b0, 1'b0, 1, 0, 8'h11, 8'h22, 8'h33);
        // Split read wrapping at FFFF.
        do_access(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 2, 8'h34, 8'h12, 8'hC3);
        // Odd byte read, sign-extending when the feature is present.
        do_access(1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0, 1'b1, 0, 0, 8'h80, 8'h00, 8'hFF);
        // Same byte read without extension request.
        do_access(1'b0, 1'b1, 16'h0011, 16'h0000, 1'b1, 1'b0, 0, 0, 8'h80, 8'h00, 8'hFF);
        // Aligned write then read: WRITE_RSP = 0 instance pulses only for the read.
        do_access(1'b1, 1'b0, 16'h0040, 16'h1357, 1'b1, 1'b0, 0, 0, 8'h00, 8'h00, 8'h5A);
        do_access(1'b0, 1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0, 0, 0, 8'h9C, 8'h7E, 8'h00);
        idle_cycle();

        // Reset while in REQ2.
        core_valid = 1'b1; core_addr = 16'h3003; core_data = 16'hCAFE;
        core_width = 1'b0; core_cmd = 1'b0; core_t_id = 1'b1;
        @(negedge clk);
        core_valid = 1'b0; rq_ack = 1'b1;
        @(negedge clk);
        rq_ack = 1'b0;
        check("pre_rst_req2", {15'd0, rq_start}, 16'd1);
        #2 a_rst = 1'b0;
        #1;
        check("mid_rst_start", {15'd0, rq_start}, 16'd0);
        check("mid_rst_ready", {15'd0, core_ready}, 16'd1);
        check("mid_rst_valid", {15'd0, rsp_valid}, 16'd0);
        check("mid_rst_data", rsp_data, 16'h0000);
        check("mid_rst_nw_ready", {15'd0, nw_core_ready}, 16'd1);
        @(negedge clk);
        a_rst = 1'b1;
        mem_rdy = 1'b1; mem_rd_data = 16'h5555;
        idle_cycle();
        mem_rdy = 1'b0;
        repeat (3) idle_cycle();
        do_access(1'b0, 1'b0, 16'h3003, 16'h0000, 1'b1, 1'b0, 2, 1, 8'hA1, 8'hB2, 8'h0F);

        // Randomized accesses, back-to-back or with short gaps.
        for (int n = 0; n < 200; n++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(7) == 0) a = 16'hFFFF;
            do_access(1'($urandom), 1'($urandom), a, 16'($urandom), 1'($urandom),
                      1'($urandom), int'($urandom_range(3)), int'($urandom_range(3)),
                      8'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(3) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_split_16b.md
Name: lsu_split_16b

Overview:
Sits directly upstream of the 16-bit load/store unit, between the core's memory-request path and the LSU request port.
Accepts one core access at a time. Splits an odd-address 16-bit access into two byte transfers. Aligned accesses pass through as a single transfer.
Watches memory completion (mem_rdy) and read data, merges byte lanes, and returns one aligned, extended 16-bit response per core access.
Little-endian: lane0 = data[7:0] = even byte; lane1 = data[15:8] = odd byte.

Parameters:
WRITE_RSP, 1, 1 = writes also pulse rsp_valid on completion; 0 = only reads produce rsp_valid.

Ports:
clk  in  1  clock, rising edge
a_rst  in  1  asynchronous active-low reset
core_valid  in  1  core request valid
core_ready  out  1  splitter can accept a request (high only in IDLE)
core_addr  in  16  byte address
core_data  in  16  write data, value in [15:0]
core_width  in  1  0 = 16-bit, 1 = 8-bit (LSU width encoding)
core_cmd  in  1  1 = write, 0 = read; forwarded unchanged
core_t_id  in  1  transaction id
rq_addr  out  16  to LSU
rq_wr_addr  out  1  to LSU; constant 1
rq_data  out  16  to LSU, lane-placed write data
rq_width  out  1  to LSU
rq_cmd  out  1  to LSU
rq_t_id  out  1  to LSU; core_t_id for both parts
rq_start  out  1  request to LSU
rq_ack  in  1  LSU accepted request
mem_rdy  in  1  memory transfer completes this cycle
mem_rd_data  in  16  memory read data, valid when mem_rdy
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  16  merged, extended read data; 16'h0000 for writes
rsp_t_id  out  1  id of the completed access

Behaviour:
- Reset (a_rst low, any state, including mid-split):
  - state = IDLE; rq_start = 0; rsp_valid = 0; rsp_data = 16'h0000; rsp_t_id = 0.
  - Latched request and low-byte holding register are cleared.
  - core_ready = 1 immediately.
- split = core_addr[0] & ~core_width, latched on accept.
- IDLE:
  - core_ready = 1; mem_rdy ignored.
  - On core_valid: latch addr, data, width, cmd, t_id and split; go to REQ1.
- REQ1: rq_start = 1.
  - Non-split: rq_addr = A; rq_width = width; rq_data = data.
    - Exception, byte access at odd A: rq_data = {data[7:0], data[7:0]}.
  - Split: rq_addr = A; rq_width = 1; rq_data = {data[7:0], data[7:0]}.
  - On rq_ack: split goes to REQ2; otherwise goes to WAIT_LAST. The LSU is idle here, so the ack comes in the same cycle.
- REQ2 (split only): rq_start = 1; rq_addr = A+1 mod 2^16 (16'hFFFF wraps to 16'h0000); rq_width = 1; rq_data = {data[15:8], data[15:8]}.
  - rq_ack coincides with part-1 mem_rdy. On it, capture lo = mem_rd_data[15:8] and go to WAIT_LAST.
  - A mem_rdy without rq_ack cannot occur; it is treated as an assertion failure in simulation.
- WAIT_LAST: rq_start = 0. On mem_rdy, go to IDLE and register the response, with rsp_valid high the next cycle (subject to WRITE_RSP).
  - Read response data:
    - word, even address: mem_rd_data.
    - word, split: {mem_rd_data[7:0], lo}.
    - byte, even address: zero-extended mem_rd_data[7:0].
    - byte, odd address: zero-extended mem_rd_data[15:8].
  - Write response data: 16'h0000.
  - rsp_t_id = latched t_id.
- rsp_valid is high for exactly one cycle; rsp_data and rsp_t_id hold until the next response.
- Latency:
  - Accept at cycle 0; REQ1 is cycle 1.
  - Aligned access: last mem_rdy at cycle N ≥ 2 gives rsp_valid at N+1.
  - Split access: part-1 mem_rdy at N1 ≥ 2, part-2 mem_rdy at N2 ≥ N1+1, rsp_valid at N2+1.
- A new request can be accepted in the cycle rsp_valid is high (state is already IDLE).

Optional Feature:
LSU_SPLIT_SEXT_EN:
- Defined: adds input core_sext (1 bit), latched on accept. Byte reads with core_sext = 1 sign-extend bit 7 of the selected byte. Word reads are unaffected.
- Undefined: the port is absent and all byte reads zero-extend.

Test Plan:
- Aligned word read, A = 16'h1000, mem_rd_data = 16'hBEEF with mem_rdy at cycle 3 -> one LSU request (addr 1000, width 0), rsp_valid at cycle 4, rsp_data = BEEF.
- Split word write, A = 16'h2001, data = 16'hA55A -> request 1 is addr 2001, width 1, rq_data 5A5A; request 2 is addr 2002, rq_data A5A5, acked on part-1 mem_rdy; one rsp_valid with rsp_data = 0000.
- Split read at 16'hFFFF: part-1 data 34xx, part-2 data xx12 -> second rq_addr = 0000, rsp_data = 1234.
- Byte read at odd address 16'h0011, mem_rd_data = 16'h80FF -> rsp_data = 0080, or FF80 with LSU_SPLIT_SEXT_EN and core_sext = 1.
- Reset asserted while in REQ2 -> rq_start = 0 and core_ready = 1 immediately; no rsp_valid afterwards; the next request proceeds normally.
- WRITE_RSP = 0, aligned write followed by a read -> no pulse for the write, one pulse for the read with the correct t_id.
